// File: rtl/rr_token_arbiter.sv
// rr_token_arbiter: merges num_inputs req/ack token channels into one
// downstream channel. It fetches one token from the granted input, holds it,
// then delivers it tagged with its source index. Grants rotate round-robin.
//
// Handshake (both sides): the token receiver holds req high as a level; the
// token sender answers with a single-cycle ack pulse, and data is valid only
// in that ack cycle. Upstream we are the receiver (req_l out, ack_l/din in);
// downstream we are the sender (req_r in, ack_r/dout/dout_src out). A token
// moves exactly on a clock edge where the receiver's req and the sender's ack
// are both sampled high.
module rr_token_arbiter #(
    parameter int data_width = 32,
    parameter int num_inputs = 4,
    parameter int id_width   = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [num_inputs-1:0]            en_mask,
    output logic [num_inputs-1:0]            req_l,
    input  logic [num_inputs-1:0]            ack_l,
    input  logic [data_width*num_inputs-1:0] din,
    input  logic                             req_r,
    output logic                             ack_r,
    output logic [data_width-1:0]            dout,
    output logic [id_width-1:0]              dout_src,
    output logic [31:0]                      grant_count,
    output logic [1:0]                       state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2,
        SEND  = 2'd3
    } state_t;

    state_t                state;
    logic [id_width-1:0]   ptr;
    logic [id_width-1:0]   sel;

    logic                  found;
    logic [id_width-1:0]   pick;
    logic [num_inputs-1:0] pick_onehot;
    logic [id_width:0]     cand_sum;
    logic [id_width-1:0]   cand;
    logic [id_width-1:0]   ptr_next;

    assign state_dbg = state;

    // After serving sel, priority moves to the input just above it.
    assign ptr_next = (sel == id_width'(num_inputs - 1)) ? '0 : sel + 1'b1;

    // First enabled input at or after ptr, wrapping modulo num_inputs.
    always_comb begin
        found       = 1'b0;
        pick        = '0;
        pick_onehot = '0;
        cand_sum    = '0;
        cand        = '0;
        for (int i = 0; i < num_inputs; i++) begin
            cand_sum = {1'b0, ptr} + (id_width + 1)'(i);
            if (cand_sum >= (id_width + 1)'(num_inputs)) begin
                cand_sum = cand_sum - (id_width + 1)'(num_inputs);
            end
            cand = cand_sum[id_width-1:0];
            if (!found && en_mask[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        pick_onehot[pick] = found;
    end

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            sel         <= '0;
            req_l       <= '0;
            ack_r       <= 1'b0;
            dout        <= '0;
            dout_src    <= '0;
            grant_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        sel   <= pick;
                        req_l <= pick_onehot;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    // Only the granted channel's ack counts; the request stays
                    // up until it arrives even if that input is since disabled.
                    if (ack_l[sel]) begin
                        dout     <= din[data_width*sel +: data_width];
                        dout_src <= sel;
                        req_l    <= '0;
                        ptr      <= ptr_next;
                        state    <= FULL;
                    end
                end
                FULL: begin
                    if (req_r) begin
                        ack_r       <= 1'b1;
                        grant_count <= grant_count + 32'd1;
                        state       <= SEND;
                    end
                end
                SEND: begin
                    ack_r <= 1'b0;
                    if (found) begin
                        sel   <= pick;
                        req_l <= pick_onehot;
                        state <= FETCH;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_token_arbiter.sv
// Bench for rr_token_arbiter: table of round-robin/mask vectors plus
// hand-written sequences for backpressure, spurious acks and async reset.
module tb_rr_token_arbiter;

    localparam int DW = 32;
    localparam int NI = 4;
    localparam int IW = 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic             clk = 1'b0;
    logic             rst;
    logic [NI-1:0]    en_mask;
    logic [NI-1:0]    req_l;
    logic [NI-1:0]    ack_l;
    logic [DW*NI-1:0] din;
    logic             req_r;
    logic             ack_r;
    logic [DW-1:0]    dout;
    logic [IW-1:0]    dout_src;
    logic [31:0]      grant_count;
    logic [1:0]       state_dbg;

    // clock / reset
    always #5 clk = ~clk;

    rr_token_arbiter #(.data_width(DW), .num_inputs(NI), .id_width(IW)) dut (
        .clk(clk), .rst(rst), .en_mask(en_mask), .req_l(req_l), .ack_l(ack_l),
        .din(din), .req_r(req_r), .ack_r(ack_r), .dout(dout),
        .dout_src(dout_src), .grant_count(grant_count), .state_dbg(state_dbg)
    );

    // upstream producers: ack one cycle after seeing req, data = 100*k + n
    logic             auto_mode;
    logic [NI-1:0]    prod_ack;
    logic [NI-1:0]    man_ack;
    logic [DW*NI-1:0] prod_din;
    logic [DW*NI-1:0] man_din;
    int unsigned      prod_cnt [NI];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_ack <= '0;
            for (int k = 0; k < NI; k++) prod_cnt[k] <= 0;
        end else begin
            for (int k = 0; k < NI; k++) begin
                if (prod_ack[k]) begin
                    prod_ack[k] <= 1'b0;
                    prod_cnt[k] <= prod_cnt[k] + 1;
                end else if (req_l[k]) begin
                    prod_ack[k] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        prod_din = '0;
        for (int k = 0; k < NI; k++) prod_din[k*DW +: DW] = 32'(100 * k) + 32'(prod_cnt[k]);
    end

    assign ack_l = auto_mode ? prod_ack : man_ack;
    assign din   = auto_mode ? prod_din : man_din;

    // scoreboard
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [NI-1:0] mask;
        logic [DW-1:0] exp_dout;
        logic [IW-1:0] exp_src;
        logic [31:0]   exp_count;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic wait_ack(input int max_cyc, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (ack_r !== 1'b1 && cyc < max_cyc);
        if (ack_r !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL ack_r_timeout: no ack_r within %0d cycles", max_cyc);
        end
    endtask

    task automatic do_reset(input logic [NI-1:0] mask);
        rst     = 1'b1;
        en_mask = mask;
        req_r   = 1'b1;
        man_ack = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int cyc;
        rst       = 1'b1;
        auto_mode = 1'b1;
        en_mask   = '0;
        req_r     = 1'b0;
        man_ack   = '0;
        man_din   = '0;

        for (int i = 0; i < 16; i++) begin
            vecs[i].mask      = 4'b1111;
            vecs[i].exp_dout  = 32'(100 * (i % 4) + i / 4);
            vecs[i].exp_src   = IW'(i % 4);
            vecs[i].exp_count = 32'(i + 1);
        end
        vecs[16] = '{4'b1010, 32'd104, 2'd1, 32'd17};
        vecs[17] = '{4'b1010, 32'd304, 2'd3, 32'd18};
        vecs[18] = '{4'b1010, 32'd105, 2'd1, 32'd19};
        vecs[19] = '{4'b1010, 32'd305, 2'd3, 32'd20};

        // single input, reset values and 4-cycle cadence
        do_reset(4'b0001);
        check("rst_req_l", 32'(req_l), 32'd0);
        check("rst_ack_r", 32'(ack_r), 32'd0);
        check("rst_dout", dout, 32'd0);
        check("rst_dout_src", 32'(dout_src), 32'd0);
        check("rst_grant_count", grant_count, 32'd0);
        check("rst_state", 32'(state_dbg), 32'(S_IDLE));
        for (int n = 0; n < 4; n++) begin
            wait_ack(20, cyc);
            check("single_latency", 32'(cyc), 32'd4);
            check("single_dout", dout, 32'(n));
            check("single_src", 32'(dout_src), 32'd0);
            check("single_count", grant_count, 32'(n + 1));
        end

        // round-robin and mask skip from the vector table
        do_reset(4'b1111);
        for (int i = 0; i < 20; i++) begin
            en_mask = vecs[i].mask;
            wait_ack(20, cyc);
            check($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
            check($sformatf("vec%0d_src", i), 32'(dout_src), 32'(vecs[i].exp_src));
            check($sformatf("vec%0d_count", i), grant_count, vecs[i].exp_count);
        end

        // mask cleared after a grant: held token still delivered, then IDLE
        @(negedge clk);
        check("held_req_l", 32'(req_l), 32'b0010);
        en_mask = 4'b0000;
        wait_ack(20, cyc);
        check("held_dout", dout, 32'd106);
        check("held_src", 32'(dout_src), 32'd1);
        check("held_count", grant_count, 32'd21);
        repeat (3) @(negedge clk);
        check("idle_state", 32'(state_dbg), 32'(S_IDLE));
        check("idle_req_l", 32'(req_l), 32'd0);
        check("idle_ack_r", 32'(ack_r), 32'd0);

        // backpressure while FULL
        req_r   = 1'b0;
        en_mask = 4'b1111;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (state_dbg !== S_FULL && cyc < 10);
        check("bp_reach_full", 32'(state_dbg), 32'(S_FULL));
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("bp_ack_r", 32'(ack_r), 32'd0);
            check("bp_dout", dout, 32'd204);
            check("bp_req_l", 32'(req_l), 32'd0);
        end
        req_r = 1'b1;
        wait_ack(5, cyc);
        check("bp_release_dout", dout, 32'd204);
        check("bp_release_src", 32'(dout_src), 32'd2);
        check("bp_release_count", grant_count, 32'd22);
        @(negedge clk);
        check("bp_single_pulse", 32'(ack_r), 32'd0);
        check("bp_next_grant", 32'(req_l), 32'b1000);

        // spurious and simultaneous acks
        auto_mode = 1'b0;
        do_reset(4'b0001);
        @(negedge clk);
        check("spur_req_l", 32'(req_l), 32'b0001);
        man_ack = 4'b0100;
        man_din[2*DW +: DW] = 32'hDEAD;
        man_din[0 +: DW]    = 32'h1234;
        @(negedge clk);
        check("spur_state", 32'(state_dbg), 32'(S_FETCH));
        check("spur_dout", dout, 32'd0);
        check("spur_req_held", 32'(req_l), 32'b0001);
        man_ack = 4'b1111;
        @(negedge clk);
        man_ack = '0;
        check("all_ack_dout", dout, 32'h1234);
        check("all_ack_src", 32'(dout_src), 32'd0);
        check("all_ack_req_l", 32'(req_l), 32'd0);
        wait_ack(5, cyc);
        check("all_ack_deliver", dout, 32'h1234);
        check("all_ack_count", grant_count, 32'd1);

        // async reset during FETCH, late ack ignored afterwards
        do_reset(4'b0010);
        @(negedge clk);
        check("mid_req_l", 32'(req_l), 32'b0010);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_req_l", 32'(req_l), 32'd0);
        check("mid_rst_state", 32'(state_dbg), 32'(S_IDLE));
        @(negedge clk);
        en_mask = 4'b0011;
        man_ack = 4'b0010;
        rst     = 1'b0;
        @(negedge clk);
        man_ack = '0;
        check("post_rst_req_l", 32'(req_l), 32'b0001);
        check("post_rst_dout", dout, 32'd0);
        check("post_rst_src", 32'(dout_src), 32'd0);
        check("post_rst_count", grant_count, 32'd0);
        check("post_rst_state", 32'(state_dbg), 32'(S_FETCH));

        // final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
